// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, immediate/ALU selects, sequencer states and opcode classes.
// Combinational helpers classify an opcode into its class and map a class to its immediate format.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_S    = 2'b10,
        IMM_B    = 2'b11
    } imm_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_CMP   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_OP,
        CLS_OPIMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } cls_t;

    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     mem_addr_sel;
        logic     ir_we;
        logic     pc_we;
        logic     pc_sel;
        imm_sel_t imm_sel;
        logic     alu_src_b;
        alu_op_t  alu_op;
        logic     rf_we;
        logic     wb_sel;
        logic     retire;
        logic     illegal;
    } ctrl_t;

    function automatic logic opc_legal(input logic [6:0] opc);
        return opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM};
    endfunction

    // Unsupported opcodes map to OP so the immediate select reads "none" while decoding them.
    function automatic cls_t opc_class(input logic [6:0] opc);
        case (opc)
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_OPIMM:  return CLS_OPIMM;
            default:    return CLS_OP;
        endcase
    endfunction

    function automatic imm_sel_t cls_imm(input cls_t c);
        case (c)
            CLS_LOAD, CLS_OPIMM: return IMM_I;
            CLS_STORE:           return IMM_S;
            CLS_BRANCH:          return IMM_B;
            default:             return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map from sequencer state and opcode class to datapath mux selects and enables.
// Only the memory-exit enables and the branch PC write look at inputs; everything else is Moore.
module ctrl_decode
    import riscv_pkg::*;
(
    input  ctrl_state_t state,
    input  cls_t        cls,
    input  logic        mem_ready,
    input  logic        br_taken,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.ir_we   = mem_ready;
                ctrl.pc_we   = mem_ready;
            end
            ST_DECODE: begin
                ctrl.imm_sel = cls_imm(cls);
            end
            ST_EXEC: begin
                ctrl.imm_sel = cls_imm(cls);
                case (cls)
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.alu_src_b = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    CLS_OPIMM: begin
                        ctrl.alu_src_b = 1'b1;
                        ctrl.alu_op    = ALU_FUNCT;
                    end
                    CLS_BRANCH: begin
                        ctrl.alu_op = ALU_CMP;
                        ctrl.pc_sel = 1'b1;
                        ctrl.pc_we  = br_taken;
                        ctrl.retire = 1'b1;
                    end
                    default: begin
                        ctrl.alu_op = ALU_FUNCT;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl.imm_sel      = cls_imm(cls);
                ctrl.mem_req      = 1'b1;
                ctrl.mem_addr_sel = 1'b1;
                ctrl.mem_we       = (cls == CLS_STORE);
                ctrl.retire       = (cls == CLS_STORE) && mem_ready;
            end
            ST_WB: begin
                ctrl.imm_sel = cls_imm(cls);
                ctrl.rf_we   = 1'b1;
                ctrl.wb_sel  = (cls == CLS_LOAD);
                ctrl.retire  = 1'b1;
            end
            ST_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on unknown opcodes.
// BRANCH 3, OP/OP-IMM/STORE 4, LOAD 5 cycles; each low mem_ready cycle in FETCH or MEM adds one.
module riscv_mc_ctrl
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [1:0]  imm_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        retire,
    output logic [31:0] instret,
    output logic        illegal
);

    ctrl_state_t state_q, state_d;
    cls_t        cls_q, cls_d, cls_dec, cls_eff;
    logic        opc_ok;
    logic [31:0] instret_q, instret_d;
    ctrl_t       ctrl, ctrl_o;
    logic        instr_unused;

    assign instr_unused = ^instr[31:7];

    // During DECODE the class register is still being loaded, so the selects come from IR directly.
    always_comb begin
        cls_dec = opc_class(instr[6:0]);
        opc_ok  = opc_legal(instr[6:0]);
        cls_eff = (state_q == ST_DECODE) ? cls_dec : cls_q;
    end

    ctrl_decode u_decode (
        .state     (state_q),
        .cls       (cls_eff),
        .mem_ready (mem_ready),
        .br_taken  (br_taken),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        instret_d = instret_q + {31'd0, ctrl.retire};
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                cls_d   = cls_dec;
                state_d = opc_ok ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM:    if (mem_ready) state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_OP;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            instret_q <= instret_d;
        end
    end

    // Reset blanks every output at once so a pending memory request is dropped, not held.
    assign ctrl_o = rst_n ? ctrl : '0;

    assign mem_req      = ctrl_o.mem_req;
    assign mem_we       = ctrl_o.mem_we;
    assign mem_addr_sel = ctrl_o.mem_addr_sel;
    assign ir_we        = ctrl_o.ir_we;
    assign pc_we        = ctrl_o.pc_we;
    assign pc_sel       = ctrl_o.pc_sel;
    assign imm_sel      = ctrl_o.imm_sel;
    assign alu_src_b    = ctrl_o.alu_src_b;
    assign alu_op       = ctrl_o.alu_op;
    assign rf_we        = ctrl_o.rf_we;
    assign wb_sel       = ctrl_o.wb_sel;
    assign retire       = ctrl_o.retire;
    assign illegal      = ctrl_o.illegal;
    assign instret      = instret_q;

endmodule
